ap_ctrl_driver: RTL

//  Synthesizable initiator for the ap_ctrl_hs handshake of one HLS kernel instance (e.g. a

---
 rtl/ap_ctrl_driver.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: ap_ctrl_hs initiator that issues bursts of kernel runs
// and emits one latency record per retired run.
module ap_ctrl_driver #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned NUM_W   = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [NUM_W-1:0] req_num,
    output logic             req_ready,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [NUM_W-1:0] rec_index,
    output logic [CNT_W-1:0] rec_latency,
    output logic             busy,
    output logic             burst_done,
    output logic [1:0]       err
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_ERROR
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wd_q;
    logic [CNT_W-1:0] wd_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      occ_q;
    logic [NUM_W-1:0] remaining_q;
    logic [NUM_W-1:0] done_idx_q;
    logic             ap_start_q;
    logic             rec_valid_q;
    logic [NUM_W-1:0] rec_index_q;
    logic [CNT_W-1:0] rec_latency_q;
    logic             burst_done_q;
    logic [1:0]       err_q;

    logic full;
    logic empty;
    logic accept;
    logic pop;
    logic push;
    logic wd_trip;

    assign full        = (occ_q == (AW+1)'(DEPTH));
    assign empty       = (occ_q == '0);
    assign accept      = ap_start_q & ap_ready;
    assign ap_continue = !rec_valid_q | rec_ready;
    assign pop         = ap_done & ap_continue & !empty;

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ap_start    = ap_start_q;
    assign rec_valid   = rec_valid_q;
    assign rec_index   = rec_index_q;
    assign rec_latency = rec_latency_q;
    assign burst_done  = burst_done_q;
    assign err         = err_q;

    // A new run may start (with timestamp push) only while the FIFO has room.
    always_comb begin
        push = 1'b0;
        unique case (state_q)
            S_IDLE:  push = req_valid && (req_num != '0);
            S_ISSUE: begin
                if (accept)
                    push = (remaining_q != NUM_W'(1)) && !full;
                else
                    push = !ap_start_q && !full && !wd_trip;
            end
            default: push = 1'b0;
        endcase
    end

    // Watchdog counts active cycles with neither an accept nor a retire.
    always_comb begin
        wd_d    = '0;
        wd_trip = 1'b0;
        if (TIMEOUT != 0 && (state_q == S_ISSUE || state_q == S_DRAIN)
            && !(accept || pop)) begin
            wd_d    = wd_q + 1'b1;
            wd_trip = (wd_d == CNT_W'(TIMEOUT));
        end
    end

    // Free-running timestamp counter and watchdog register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            wd_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            wd_q  <= wd_d;
        end
    end

    // Timestamp FIFO pointers; the pushed stamp is the cycle ap_start is first high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Timestamp FIFO storage.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= cnt_q + 1'b1;
    end

    // Control FSM with registered handshake, record and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            remaining_q   <= '0;
            done_idx_q    <= '0;
            ap_start_q    <= 1'b0;
            rec_valid_q   <= 1'b0;
            rec_index_q   <= '0;
            rec_latency_q <= '0;
            burst_done_q  <= 1'b0;
            err_q         <= '0;
        end else begin
            burst_done_q <= 1'b0;
            if (ap_done && empty) err_q[1] <= 1'b1;
            if (pop) begin
                rec_valid_q   <= 1'b1;
                rec_latency_q <= cnt_q - mem_q[rd_q];
                rec_index_q   <= done_idx_q;
                done_idx_q    <= done_idx_q + 1'b1;
            end else if (rec_ready) begin
                rec_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && req_num != '0) begin
                        state_q     <= S_ISSUE;
                        remaining_q <= req_num;
                        done_idx_q  <= '0;
                        ap_start_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (wd_trip) begin
                        state_q    <= S_ERROR;
                        err_q[0]   <= 1'b1;
                        ap_start_q <= 1'b0;
                    end else if (accept) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == NUM_W'(1)) begin
                            state_q    <= S_DRAIN;
                            ap_start_q <= 1'b0;
                        end else begin
                            ap_start_q <= push;
                        end
                    end else if (push) begin
                        ap_start_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (wd_trip) begin
                        state_q  <= S_ERROR;
                        err_q[0] <= 1'b1;
                    end else if (empty && !ap_done) begin
                        state_q      <= S_IDLE;
                        burst_done_q <= 1'b1;
                    end
                end
                S_ERROR: ap_start_q <= 1'b0;
            endcase
        end
    end

endmodule
